// File: rtl/chunked_adder_seq_if.sv
// Request/response bundle for chunked_adder_seq.
//   master: drives in_valid, A, B, sub, out_ready; observes the rest.
//   slave : the sequencer side; drives in_ready, out_valid, result, flags, busy.
interface chunked_adder_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, result, negative, zero, overflow, carry, busy
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, result, negative, zero, overflow, carry, busy
  );
endinterface

// File: rtl/chunked_adder_seq.sv
// WIDTH-bit add/subtract computed over NCHUNK cycles on one CHUNK-bit ripple adder.
//   clk   : clock, all state on posedge
//   reset : synchronous, active-high
//   bus   : chunked_adder_seq_if.slave (in_valid/in_ready/A/B/sub request,
//           out_valid/out_ready/result/negative/zero/overflow/carry response, busy)

// CHUNK-bit ripple-carry adder used as the shared slice.
module fullAdder_VAR #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum[i]  = a[i] ^ b[i] ^ c[i];
      c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[WIDTH];
  end
endmodule

module chunked_adder_seq #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input logic           clk,
  input logic           reset,
  chunked_adder_seq_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 2) begin : g_bad_params
      $error("chunked_adder_seq: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_l, b_l;
  logic [KW-1:0]    k_q;
  logic             carry_r;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, overflow_q;
  logic             out_valid_q, busy_q, in_ready_q;

  logic [31:0]      idx;
  logic [CHUNK-1:0] a_slice, b_slice, sum;
  logic             cout, cin_msb, last_slice;

  // Current slice selection and the shared adder.
  assign idx        = 32'(k_q) * 32'(CHUNK);
  assign a_slice    = a_l[idx +: CHUNK];
  assign b_slice    = b_l[idx +: CHUNK];
  assign last_slice = (k_q == KW'(NCHUNK - 1));

  fullAdder_VAR #(.WIDTH(CHUNK)) u_adder (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_r),
    .sum  (sum),
    .cout (cout)
  );

  // Carry into the slice MSB, recovered from the sum bit, for signed overflow.
  assign cin_msb = sum[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_slice)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake/status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  // Operand latch and slice-by-slice datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_l        <= '0;
      b_l        <= '0;
      k_q        <= '0;
      carry_r    <= 1'b0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_l     <= bus.A;
            b_l     <= bus.sub ? ~bus.B : bus.B;
            carry_r <= bus.sub;
            k_q     <= '0;
          end
        end
        RUN: begin
          result_q[idx +: CHUNK] <= sum;
          carry_r                <= cout;
          k_q                    <= last_slice ? '0 : k_q + KW'(1);
          if (last_slice) begin
            carry_q    <= cout;
            overflow_q <= cout ^ cin_msb;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.negative  = result_q[WIDTH-1];
  assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_chunked_adder_seq.sv
module tb_chunked_adder_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, sub, out_ready;
  logic [63:0] A, B;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_adder_seq_if #(.WIDTH(64)) if0 ();
  chunked_adder_seq_if #(.WIDTH(64)) if1 ();
  chunked_adder_seq_if #(.WIDTH(64)) if2 ();

  assign if0.in_valid = in_valid; assign if0.A = A; assign if0.B = B;
  assign if0.sub = sub; assign if0.out_ready = out_ready;
  assign if1.in_valid = in_valid; assign if1.A = A; assign if1.B = B;
  assign if1.sub = sub; assign if1.out_ready = out_ready;
  assign if2.in_valid = in_valid; assign if2.A = A; assign if2.B = B;
  assign if2.sub = sub; assign if2.out_ready = out_ready;

  chunked_adder_seq #(.WIDTH(64), .CHUNK(16)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  chunked_adder_seq #(.WIDTH(64), .CHUNK(64)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  chunked_adder_seq #(.WIDTH(64), .CHUNK(8))  dut2 (.clk(clk), .reset(reset), .bus(if2));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] res;
    logic [3:0]  nzvc;
  } vec_t;

  int          lat  [3];
  logic [63:0] res  [3];
  logic [3:0]  fl   [3];
  int          exp_lat [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int c);
    if (lat[0] == 0 && if0.out_valid) begin
      lat[0] = c; res[0] = if0.result;
      fl[0] = {if0.negative, if0.zero, if0.overflow, if0.carry};
    end
    if (lat[1] == 0 && if1.out_valid) begin
      lat[1] = c; res[1] = if1.result;
      fl[1] = {if1.negative, if1.zero, if1.overflow, if1.carry};
    end
    if (lat[2] == 0 && if2.out_valid) begin
      lat[2] = c; res[2] = if2.result;
      fl[2] = {if2.negative, if2.zero, if2.overflow, if2.carry};
    end
  endtask

  // One accepted op with out_ready held high; operands scrambled after accept.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s);
    A = a; B = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    sub = ~s;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; res[i] = '0; fl[i] = '0;
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      capture(c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [8];
    logic seen;
    int   waited;

    exp_lat[0] = 4; exp_lat[1] = 1; exp_lat[2] = 8;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h0,                   4'b0101};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010};
    vecs[2] = '{64'd5, 64'd5, 1'b1, 64'h0,                                     4'b0101};
    vecs[3] = '{64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE,                   4'b1000};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[5] = '{64'd1, 64'd2, 1'b0, 64'd3,                                     4'b0000};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    vecs[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 4'b0111};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state on all three configurations.
    check("rst0_in_ready",  64'(if0.in_ready), 64'd1);
    check("rst0_out_valid", 64'(if0.out_valid), 64'd0);
    check("rst0_busy",      64'(if0.busy), 64'd0);
    check("rst0_result",    if0.result, 64'd0);
    check("rst0_nvc",       64'({if0.negative, if0.overflow, if0.carry}), 64'd0);
    check("rst1_in_ready",  64'(if1.in_ready), 64'd1);
    check("rst1_result",    if1.result, 64'd0);
    check("rst2_in_ready",  64'(if2.in_ready), 64'd1);
    check("rst2_result",    if2.result, 64'd0);

    // Directed vectors applied to CHUNK=16, 64 and 8 simultaneously.
    for (int v = 0; v < 8; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].s);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("v%0d_d%0d_latency", v, d), 64'(lat[d]), 64'(exp_lat[d]));
        check($sformatf("v%0d_d%0d_result", v, d), res[d], vecs[v].res);
        check($sformatf("v%0d_d%0d_nzvc", v, d), 64'(fl[d]), 64'(vecs[v].nzvc));
      end
    end

    // Back-pressure: result held while out_ready=0 and new requests are ignored.
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; sub = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    waited = 0;
    while (!if0.out_valid && waited < 12) begin
      tick();
      waited++;
    end
    check("hold_latency", 64'(waited), 64'd4);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = {$urandom, $urandom}; B = {$urandom, $urandom}; sub = 1'($urandom);
      tick();
      check($sformatf("hold%0d_out_valid", i), 64'(if0.out_valid), 64'd1);
      check($sformatf("hold%0d_in_ready", i), 64'(if0.in_ready), 64'd0);
      check($sformatf("hold%0d_result", i), if0.result, 64'd0);
      check($sformatf("hold%0d_zcv", i), 64'({if0.zero, if0.carry, if0.overflow}), 64'b110);
    end
    // Release with in_valid still high: no accept on the leaving edge.
    out_ready = 1'b1;
    tick();
    check("release_in_ready",  64'(if0.in_ready), 64'd1);
    check("release_out_valid", 64'(if0.out_valid), 64'd0);
    check("release_busy",      64'(if0.busy), 64'd0);
    in_valid = 1'b0;
    repeat (12) tick();
    check("drain_all_idle", 64'({if0.in_ready, if1.in_ready, if2.in_ready}), 64'b111);

    // Reset in the middle of RUN discards the operation.
    A = 64'hFFFF_FFFF_FFFF_FFFF; B = 64'd1; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("midrun_busy", 64'(if0.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_in_ready",  64'(if0.in_ready), 64'd1);
    check("midrst_busy",      64'(if0.busy), 64'd0);
    check("midrst_out_valid", 64'(if0.out_valid), 64'd0);
    check("midrst_result",    if0.result, 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (if0.out_valid) seen = 1'b1;
    end
    check("midrst_no_emit", 64'(seen), 64'd0);
    run_op(64'd1, 64'd2, 1'b0);
    check("post_rst_latency", 64'(lat[0]), 64'd4);
    check("post_rst_result",  res[0], 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
